permute_pipe: RTL and testbench
===============================

// Module: permute_pipe
// PURPOSE
// - Parametrised odd-pipe permute unit: quadword shift/rotate by bits/bytes, RR and RI7 forms.
// - Issue stage drives it from RF/FWD; result retires to the WB stage after LATENCY cycles.
// - Valid tags, flush and illegal-op flag added over the fixed 4-stage shift-only unit.
// PARAMETERS
// - DATA_W   128  register width; multiple of 8, power of two, >=16
// - LATENCY  4    pipeline stages issue->WB; >=1
// - ADDR_W   7    destination register address width
// - OP_W     11   decoded opcode width (truncated per format, left-aligned bit 0)
// - IMM_W    18   immediate width; RI7 count in imm[IMM_W-7:IMM_W-1]
// PORTS
// - clk           in   1       clock, rising edge
// - reset         in   1       synchronous, active-high
// - issue_valid   in   1       instruction presented this cycle
// - flush         in   1       kill all in-flight and same-cycle instructions
// - op            in   OP_W    decoded opcode
// - format        in   3       0=RR, 1=RRR, 2=RI7; others illegal
// - rt_addr       in   ADDR_W  destination register
// - ra, rb, rc    in   DATA_W  source operands (rc used only by shufb)
// - imm           in   IMM_W   immediate
// - reg_write     in   1       instruction writes register file
// - rt_wb         out  DATA_W  result at WB
// - rt_addr_wb    out  ADDR_W  destination at WB
// - reg_write_wb  out  1       valid_wb & reg_write of that instruction
// - valid_wb      out  1       live instruction at WB
// - illegal_op    out  1       1-cycle pulse, cycle after an unrecognised valid issue
// BEHAVIOUR
// - Reset: every stage and output = 0 (rt_wb, rt_addr_wb, reg_write_wb, valid_wb, illegal_op).
// - Latency: issue at edge N -> outputs valid after edge N+LATENCY; one issue/cycle, no stall.
// - Stage 0 computes the result; stages 1..LATENCY-1 delay it; WB outputs are registered.
// - Bubble (valid=0, all fields 0): issue_valid=0, or format 0 with op=0 (nop), or illegal op.
// - Counts: NB = DATA_W/8, BW = log2(NB); ra bit 0 = MSB.
// - RR ops, format 0 (bit count = rb[29:31], byte count = rb[27:31], DATA_W=128 slot 0):
//   - shlqbi 00111011011: ra << bits (0..7), zero fill
//   - rotqbi 00111011000: ra rotated left by bits (0..7)
//   - shlqby 00111011111: ra << 8*bytes; byte count >= NB -> result 0
//   - rotqby 00111011100: ra rotated left by 8*(bytes mod NB)
// - RI7 ops, format 2 (7-bit count c = imm[IMM_W-7:IMM_W-1]):
//   - shlqbii 00111111011 (c[4:6]), rotqbii 00111111000, shlqbyi 00111111111 (c[2:6]),
//     rotqbyi 00111111100; same semantics as the RR forms.
// - Generalised DATA_W: byte count is the low BW+1 bits of the preferred-slot word.
// - Illegal: valid issue, op/format not listed (or shufb with macro off) -> bubble + illegal_op.
// - flush=1: all stages and issue capture cleared on that edge. WB outputs clear next edge.
//   Same-cycle issue is discarded, illegal_op is not raised, and flush beats issue.
// - flush held: pipeline stays empty; first issue after release appears LATENCY cycles later.
// - Reset mid-operation: in-flight results lost, never reach WB; reset beats flush and issue.
// - Back-to-back issues retire in order on consecutive cycles; no reordering, no merging.
// CONFIGURATION
// - PERMUTE_SHUFB_EN defined: format 1, op[0:3]=1011 is shufb rt,ra,rb,rc.
//   - Control byte c in rc selects: 10xxxxxx->0x00, 110xxxxx->0xFF, 111xxxxx->0x80.
//   - Otherwise c[3:7] indexes the 32-byte concat {ra,rb}; index mod 2*NB for general DATA_W.
// - Not defined: format 1 is illegal (bubble + illegal_op); rc is ignored, no shufb logic.
// TESTING
// - Reset for 2 cycles then release -> all outputs 0; first valid_wb never before edge LATENCY.
// - shlqbi: ra=128'h1, rb[29:31]=3, rt=5, reg_write=1 -> after 4 cycles rt_wb=128'h8, rt_addr_wb=5.
// - rotqby: ra=128'h0102...0F10, bytes=1 -> rt_wb=128'h0203...1001.
//   shlqby with bytes=16 -> rt_wb=0.
// - 6 back-to-back issues, nop in 3rd -> 5 results in order; bubble cycle has valid_wb=0.
// - flush with 3 in flight plus same-cycle issue -> no valid_wb for 4 cycles, illegal_op=0.
// - format 2, op=00111111111, c=2, ra=128'hFF -> rt_wb=128'hFF0000.
//   format 5 -> illegal_op next cycle, valid_wb=0.
// - PERMUTE_SHUFB_EN: rc bytes 0x10..0x1F -> rt_wb=rb; rc=all 0xC0 -> rt_wb all 0xFF.

Source files
------------

// File: rtl/permute_pipe_if.sv
// Issue/WB bundle of the odd-pipe permute unit: issue-stage operands in, WB result out.
interface permute_pipe_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned OP_W   = 11,
    parameter int unsigned IMM_W  = 18
);
    logic              issue_valid;
    logic              flush;
    logic [OP_W-1:0]   op;
    logic [2:0]        format;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] rc;
    logic [IMM_W-1:0]  imm;
    logic              reg_write;

    logic [DATA_W-1:0] rt_wb;
    logic [ADDR_W-1:0] rt_addr_wb;
    logic              reg_write_wb;
    logic              valid_wb;
    logic              illegal_op;

    // Issue stage side
    modport master (
        output issue_valid, flush, op, format, rt_addr, ra, rb, rc, imm, reg_write,
        input  rt_wb, rt_addr_wb, reg_write_wb, valid_wb, illegal_op
    );

    // Permute unit side
    modport slave (
        input  issue_valid, flush, op, format, rt_addr, ra, rb, rc, imm, reg_write,
        output rt_wb, rt_addr_wb, reg_write_wb, valid_wb, illegal_op
    );
endinterface

// File: rtl/permute_pipe.sv
// Odd-pipe permute unit: quadword shift/rotate by bits/bytes (RR and RI7 forms),
// LATENCY pipeline stages plus a registered WB stage, valid tags, flush, illegal-op pulse.
// Optional shufb (format 1) is enabled by defining PERMUTE_SHUFB_EN.
// Bit numbering follows the ISA: operand bit 0 is the MSB, so the preferred slot is the top word.
module permute_pipe #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned OP_W    = 11,
    parameter int unsigned IMM_W   = 18
) (
    input  logic          clk,
    input  logic          reset,
    permute_pipe_if.slave bus
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned BW     = $clog2(NB);
    localparam int unsigned AMT_W  = BW + 3;
    localparam int unsigned SLOT_W = (DATA_W < 32) ? DATA_W : 32;

    localparam logic [OP_W-1:0] OP_NOP     = '0;
    localparam logic [OP_W-1:0] OP_SHLQBI  = OP_W'(11'b00111011011);
    localparam logic [OP_W-1:0] OP_ROTQBI  = OP_W'(11'b00111011000);
    localparam logic [OP_W-1:0] OP_SHLQBY  = OP_W'(11'b00111011111);
    localparam logic [OP_W-1:0] OP_ROTQBY  = OP_W'(11'b00111011100);
    localparam logic [OP_W-1:0] OP_SHLQBII = OP_W'(11'b00111111011);
    localparam logic [OP_W-1:0] OP_ROTQBII = OP_W'(11'b00111111000);
    localparam logic [OP_W-1:0] OP_SHLQBYI = OP_W'(11'b00111111111);
    localparam logic [OP_W-1:0] OP_ROTQBYI = OP_W'(11'b00111111100);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic              w_known;
    logic              w_nop;
    logic              w_rot;
    logic              w_byte;
    logic [31:0]       w_cnt_word;
    logic [BW:0]       w_bytes;
    logic [AMT_W-1:0]  w_amt;
    logic [2*DATA_W-1:0] w_dbl;
    logic [DATA_W-1:0] w_rotv;
    logic [DATA_W-1:0] w_shlv;
    logic [DATA_W-1:0] w_res;
    logic              w_live;
    logic              w_illegal;
    stage_t            w_s0;

    stage_t            r_stg [LATENCY];
    stage_t            r_wb;
    logic              r_illegal;

`ifdef PERMUTE_SHUFB_EN
    localparam int unsigned IDX_W = (BW + 1 < 5) ? BW + 1 : 5;
    logic              w_shufb;
    logic [2*DATA_W-1:0] w_cat;
    logic [DATA_W-1:0] w_shuf;
`endif

    // Opcode/format decode into operation class flags
    always_comb begin
        w_known = 1'b0;
        w_nop   = 1'b0;
        w_rot   = 1'b0;
        w_byte  = 1'b0;
`ifdef PERMUTE_SHUFB_EN
        w_shufb = 1'b0;
`endif
        case (bus.format)
            3'd0: begin
                case (bus.op)
                    OP_NOP:    w_nop = 1'b1;
                    OP_SHLQBI: w_known = 1'b1;
                    OP_ROTQBI: begin w_known = 1'b1; w_rot = 1'b1; end
                    OP_SHLQBY: begin w_known = 1'b1; w_byte = 1'b1; end
                    OP_ROTQBY: begin w_known = 1'b1; w_byte = 1'b1; w_rot = 1'b1; end
                    default:   ;
                endcase
            end
            3'd2: begin
                case (bus.op)
                    OP_SHLQBII: w_known = 1'b1;
                    OP_ROTQBII: begin w_known = 1'b1; w_rot = 1'b1; end
                    OP_SHLQBYI: begin w_known = 1'b1; w_byte = 1'b1; end
                    OP_ROTQBYI: begin w_known = 1'b1; w_byte = 1'b1; w_rot = 1'b1; end
                    default:    ;
                endcase
            end
`ifdef PERMUTE_SHUFB_EN
            3'd1: begin
                if (bus.op[OP_W-1 -: 4] == 4'b1011) begin
                    w_known = 1'b1;
                    w_shufb = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Count source: preferred-slot word of rb for RR, the 7-bit immediate field for RI7
    assign w_cnt_word = (bus.format == 3'd2) ? 32'(bus.imm[6:0]) : 32'(bus.rb[DATA_W-1 -: SLOT_W]);
    assign w_bytes    = w_cnt_word[BW:0];
    assign w_amt      = w_byte ? {w_bytes[BW-1:0], 3'b000} : AMT_W'(w_cnt_word[2:0]);
    assign w_dbl      = {bus.ra, bus.ra} << w_amt;
    assign w_rotv     = w_dbl[2*DATA_W-1 -: DATA_W];
    assign w_shlv     = bus.ra << w_amt;

`ifdef PERMUTE_SHUFB_EN
    assign w_cat = {bus.ra, bus.rb};

    // Per-byte shuffle: constant patterns for 10x/110/111 controls, else index into {ra,rb}
    always_comb begin
        w_shuf = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (bus.rc[DATA_W-1-8*i -: 2] == 2'b10)
                w_shuf[DATA_W-1-8*i -: 8] = 8'h00;
            else if (bus.rc[DATA_W-1-8*i -: 3] == 3'b110)
                w_shuf[DATA_W-1-8*i -: 8] = 8'hFF;
            else if (bus.rc[DATA_W-1-8*i -: 3] == 3'b111)
                w_shuf[DATA_W-1-8*i -: 8] = 8'h80;
            else
                w_shuf[DATA_W-1-8*i -: 8] =
                    w_cat[2*DATA_W-1-8*int'(bus.rc[DATA_W-8-8*i +: IDX_W]) -: 8];
        end
    end
`endif

    // Result select; a byte shift of NB or more clears the quadword
    always_comb begin
        w_res = w_shlv;
`ifdef PERMUTE_SHUFB_EN
        if (w_shufb)
            w_res = w_shuf;
        else
`endif
        if (w_rot)
            w_res = w_rotv;
        else if (w_byte && w_bytes[BW])
            w_res = '0;
    end

    // Stage-0 payload: live instructions carry their fields, everything else is an all-zero bubble
    assign w_live    = bus.issue_valid & ~bus.flush & w_known;
    assign w_illegal = bus.issue_valid & ~bus.flush & ~w_known & ~w_nop;

    always_comb begin
        w_s0 = '0;
        if (w_live) begin
            w_s0.valid     = 1'b1;
            w_s0.reg_write = bus.reg_write;
            w_s0.addr      = bus.rt_addr;
            w_s0.data      = w_res;
        end
    end

    // Pipeline advance; flush empties the stages, WB keeps taking the last stage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(LATENCY); k++) r_stg[k] <= '0;
            r_wb      <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (bus.flush) begin
                for (int k = 0; k < int'(LATENCY); k++) r_stg[k] <= '0;
            end else begin
                r_stg[0] <= w_s0;
                for (int k = 1; k < int'(LATENCY); k++) r_stg[k] <= r_stg[k-1];
            end
            r_wb      <= r_stg[LATENCY-1];
            r_illegal <= w_illegal;
        end
    end

    assign bus.rt_wb        = r_wb.data;
    assign bus.rt_addr_wb   = r_wb.addr;
    assign bus.reg_write_wb = r_wb.valid & r_wb.reg_write;
    assign bus.valid_wb     = r_wb.valid;
    assign bus.illegal_op   = r_illegal;

    // Operand bits that the selected forms never look at
    logic w_unused_sink;
`ifdef PERMUTE_SHUFB_EN
    assign w_unused_sink = ^{bus.rb, bus.imm, w_cnt_word, w_dbl[DATA_W-1:0]};
`else
    assign w_unused_sink = ^{bus.rb, bus.rc, bus.imm, w_cnt_word, w_dbl[DATA_W-1:0]};
`endif
endmodule

// File: tb/tb_permute_pipe.sv
// Directed bench for permute_pipe: reset, RR/RI7 shift/rotate forms, bubbles, illegal ops,
// back-to-back ordering, flush and reset behaviour, optional shufb.
module tb_permute_pipe;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned OP_W    = 11;
    localparam int unsigned IMM_W   = 18;

    localparam logic [10:0] SHLQBI  = 11'b00111011011;
    localparam logic [10:0] ROTQBI  = 11'b00111011000;
    localparam logic [10:0] SHLQBY  = 11'b00111011111;
    localparam logic [10:0] ROTQBY  = 11'b00111011100;
    localparam logic [10:0] SHLQBII = 11'b00111111011;
    localparam logic [10:0] ROTQBII = 11'b00111111000;
    localparam logic [10:0] SHLQBYI = 11'b00111111111;
    localparam logic [10:0] ROTQBYI = 11'b00111111100;
    localparam logic [10:0] SHUFB   = 11'b10110000000;

    localparam logic [127:0] SEQ  = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] SEQ1 = 128'h02030405060708090A0B0C0D0E0F1001;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    permute_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .IMM_W(IMM_W)) bus ();

    permute_pipe #(
        .DATA_W(DATA_W), .LATENCY(LATENCY), .ADDR_W(ADDR_W), .OP_W(OP_W), .IMM_W(IMM_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.op          = '0;
        bus.format      = '0;
        bus.rt_addr     = '0;
        bus.ra          = '0;
        bus.rb          = '0;
        bus.rc          = '0;
        bus.imm         = '0;
        bus.reg_write   = 1'b0;
    endtask

    task automatic issue(input logic [2:0] fmt, input logic [10:0] op, input logic [127:0] ra,
                         input logic [127:0] rb, input logic [127:0] rc, input logic [17:0] imm,
                         input logic [6:0] rt, input logic rw);
        bus.issue_valid = 1'b1;
        bus.flush       = 1'b0;
        bus.format      = fmt;
        bus.op          = op;
        bus.ra          = ra;
        bus.rb          = rb;
        bus.rc          = rc;
        bus.imm         = imm;
        bus.rt_addr     = rt;
        bus.reg_write   = rw;
    endtask

    // One isolated instruction: illegal flag one cycle later, nothing early, result at LATENCY
    task automatic run_one(input string tag, input logic [2:0] fmt, input logic [10:0] op,
                           input logic [127:0] ra, input logic [127:0] rb, input logic [127:0] rc,
                           input logic [17:0] imm, input logic [6:0] rt, input logic rw,
                           input logic exp_v, input logic exp_ill, input logic [127:0] exp_d);
        issue(fmt, op, ra, rb, rc, imm, rt, rw);
        tick();
        idle();
        chk({tag, ".illegal"}, 128'(bus.illegal_op), 128'(exp_ill));
        repeat (LATENCY - 1) begin
            tick();
            chk({tag, ".early_valid"}, 128'(bus.valid_wb), 128'd0);
            chk({tag, ".illegal_pulse"}, 128'(bus.illegal_op), 128'd0);
        end
        tick();
        chk({tag, ".valid"}, 128'(bus.valid_wb), 128'(exp_v));
        chk({tag, ".data"}, bus.rt_wb, exp_v ? exp_d : 128'd0);
        chk({tag, ".addr"}, 128'(bus.rt_addr_wb), exp_v ? 128'(rt) : 128'd0);
        chk({tag, ".regwr"}, 128'(bus.reg_write_wb), exp_v ? 128'(rw) : 128'd0);
        tick();
        chk({tag, ".drain"}, 128'(bus.valid_wb), 128'd0);
    endtask

    logic [127:0] b2b_d [6];
    logic         b2b_v [6];
    logic [6:0]   b2b_a [6];

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst.rt_wb", bus.rt_wb, 128'd0);
        chk("rst.addr", 128'(bus.rt_addr_wb), 128'd0);
        chk("rst.regwr", 128'(bus.reg_write_wb), 128'd0);
        chk("rst.valid", 128'(bus.valid_wb), 128'd0);
        chk("rst.illegal", 128'(bus.illegal_op), 128'd0);
        reset = 1'b0;
        repeat (LATENCY) begin
            tick();
            chk("post_rst.valid", 128'(bus.valid_wb), 128'd0);
        end

        // RR forms
        run_one("shlqbi", 3'd0, SHLQBI, 128'h1, 128'h00000003_00000000_00000000_00000000,
                '0, '0, 7'd5, 1'b1, 1'b1, 1'b0, 128'h8);
        run_one("rotqbi", 3'd0, ROTQBI, 128'h80000000_00000000_00000000_00000001,
                128'hFFFFFFF9_DEADBEEF_DEADBEEF_DEADBEEF, '0, '0, 7'd6, 1'b1, 1'b1, 1'b0, 128'h3);
        run_one("rotqby1", 3'd0, ROTQBY, SEQ, 128'h00000001_00000000_00000000_00000000,
                '0, '0, 7'd2, 1'b1, 1'b1, 1'b0, SEQ1);
        run_one("rotqby17", 3'd0, ROTQBY, SEQ, 128'h00000011_00000000_00000000_00000000,
                '0, '0, 7'd3, 1'b1, 1'b1, 1'b0, SEQ1);
        run_one("shlqby16", 3'd0, SHLQBY, SEQ, 128'h00000010_00000000_00000000_00000000,
                '0, '0, 7'd7, 1'b1, 1'b1, 1'b0, 128'd0);
        run_one("shlqby2", 3'd0, SHLQBY, SEQ, 128'h00000002_00000000_00000000_00000000,
                '0, '0, 7'd8, 1'b1, 1'b1, 1'b0, 128'h030405060708090A0B0C0D0E0F100000);
        run_one("no_regwr", 3'd0, SHLQBI, 128'h1, 128'd0, '0, '0, 7'd9, 1'b0, 1'b1, 1'b0, 128'h1);

        // RI7 forms
        run_one("shlqbyi", 3'd2, SHLQBYI, 128'hFF, '0, '0, 18'd2, 7'd10, 1'b1, 1'b1, 1'b0, 128'hFF0000);
        run_one("rotqbii", 3'd2, ROTQBII, 128'h80000000_00000000_00000000_00000000, '0, '0,
                18'h3FFF9, 7'd11, 1'b1, 1'b1, 1'b0, 128'h1);
        run_one("shlqbii", 3'd2, SHLQBII, 128'h1, '0, '0, 18'd7, 7'd12, 1'b1, 1'b1, 1'b0, 128'h80);
        run_one("rotqbyi", 3'd2, ROTQBYI, SEQ, '0, '0, 18'h00011, 7'd13, 1'b1, 1'b1, 1'b0, SEQ1);

        // Bubbles and illegal encodings
        run_one("nop", 3'd0, 11'd0, SEQ, '0, '0, '0, 7'd14, 1'b1, 1'b0, 1'b0, 128'd0);
        run_one("fmt5", 3'd5, SHLQBI, SEQ, '0, '0, '0, 7'd15, 1'b1, 1'b0, 1'b1, 128'd0);
        run_one("rr_op_in_ri7", 3'd2, SHLQBI, SEQ, '0, '0, '0, 7'd16, 1'b1, 1'b0, 1'b1, 128'd0);
        run_one("ri7_op_in_rr", 3'd0, SHLQBII, SEQ, '0, '0, '0, 7'd17, 1'b1, 1'b0, 1'b1, 128'd0);

`ifdef PERMUTE_SHUFB_EN
        run_one("shufb_rb", 3'd1, SHUFB, SEQ, 128'h1112131415161718191A1B1C1D1E1F20,
                128'h101112131415161718191A1B1C1D1E1F, '0, 7'd3, 1'b1, 1'b1, 1'b0,
                128'h1112131415161718191A1B1C1D1E1F20);
        run_one("shufb_ff", 3'd1, SHUFB, SEQ, 128'h1112131415161718191A1B1C1D1E1F20,
                {16{8'hC0}}, '0, 7'd3, 1'b1, 1'b1, 1'b0, {16{8'hFF}});
        run_one("shufb_mix", 3'd1, SHUFB, SEQ, 128'h1112131415161718191A1B1C1D1E1F20,
                128'h000F8000E0C01F100102030405060708, '0, 7'd3, 1'b1, 1'b1, 1'b0,
                128'h0110000180FF20110203040506070809);
`else
        run_one("shufb_off", 3'd1, SHUFB, SEQ, SEQ, SEQ, '0, 7'd3, 1'b1, 1'b0, 1'b1, 128'd0);
`endif

        // Six back-to-back issues, the third a nop: five in-order results, one bubble
        b2b_d = '{128'd1, 128'd4, 128'd0, 128'd32, 128'd80, 128'd192};
        b2b_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        b2b_a = '{7'd10, 7'd11, 7'd0, 7'd13, 7'd14, 7'd15};
        for (int c = 0; c < 6 + int'(LATENCY); c++) begin
            if (c == 2)
                issue(3'd0, 11'd0, 128'd3, '0, '0, '0, 7'd12, 1'b1);
            else if (c < 6)
                issue(3'd0, SHLQBI, 128'(c + 1), {32'(c), 96'd0}, '0, '0, 7'(10 + c), 1'b1);
            else
                idle();
            tick();
            if (c >= int'(LATENCY)) begin
                chk("b2b.valid", 128'(bus.valid_wb), 128'(b2b_v[c - int'(LATENCY)]));
                chk("b2b.data", bus.rt_wb, b2b_d[c - int'(LATENCY)]);
                chk("b2b.addr", 128'(bus.rt_addr_wb), 128'(b2b_a[c - int'(LATENCY)]));
            end
        end
        idle();
        tick();
        chk("b2b.drain", 128'(bus.valid_wb), 128'd0);

        // Flush with three in flight plus a same-cycle illegal issue
        issue(3'd0, SHLQBI, 128'h1, '0, '0, '0, 7'd1, 1'b1);
        tick();
        issue(3'd0, SHLQBI, 128'h2, '0, '0, '0, 7'd2, 1'b1);
        tick();
        issue(3'd0, SHLQBI, 128'h3, '0, '0, '0, 7'd3, 1'b1);
        tick();
        issue(3'd5, SHLQBI, 128'h4, '0, '0, '0, 7'd4, 1'b1);
        bus.flush = 1'b1;
        tick();
        idle();
        chk("flush.illegal", 128'(bus.illegal_op), 128'd0);
        chk("flush.valid0", 128'(bus.valid_wb), 128'd0);
        repeat (LATENCY) begin
            tick();
            chk("flush.valid", 128'(bus.valid_wb), 128'd0);
            chk("flush.illegal_later", 128'(bus.illegal_op), 128'd0);
        end

        // Flush held for three cycles while issuing, then one clean issue
        issue(3'd5, SHLQBI, 128'h5, '0, '0, '0, 7'd5, 1'b1);
        bus.flush = 1'b1;
        repeat (3) begin
            tick();
            chk("hold.valid", 128'(bus.valid_wb), 128'd0);
            chk("hold.illegal", 128'(bus.illegal_op), 128'd0);
        end
        run_one("after_flush", 3'd0, ROTQBY, SEQ, 128'h00000001_00000000_00000000_00000000,
                '0, '0, 7'd20, 1'b1, 1'b1, 1'b0, SEQ1);

        // Reset mid-operation beats flush and issue; in-flight results never retire
        issue(3'd0, SHLQBI, 128'h7, '0, '0, '0, 7'd21, 1'b1);
        tick();
        issue(3'd0, SHLQBI, 128'h9, '0, '0, '0, 7'd22, 1'b1);
        tick();
        reset = 1'b1;
        bus.flush = 1'b1;
        issue(3'd6, SHLQBI, 128'hA, '0, '0, '0, 7'd23, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        idle();
        chk("midrst.illegal", 128'(bus.illegal_op), 128'd0);
        repeat (LATENCY + 1) begin
            tick();
            chk("midrst.valid", 128'(bus.valid_wb), 128'd0);
            chk("midrst.data", bus.rt_wb, 128'd0);
        end
        run_one("after_rst", 3'd2, SHLQBYI, 128'hFF, '0, '0, 18'd2, 7'd24, 1'b1, 1'b1, 1'b0, 128'hFF0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
